// File: rtl/sr_pulse_pkg.sv
// sr_pulse_pkg: shared FSM state type and default timing constants for the SR pulse controller
package sr_pulse_pkg;
   typedef enum logic [1:0] {IDLE, SET_PULSE, RST_PULSE} state_e;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_PULSE_CYCLES = 4;
endpackage

// File: rtl/sr_debounce_ch.sv
// sr_debounce_ch: synchronise, debounce and rise-detect one raw push-button input
module sr_debounce_ch
   import sr_pulse_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic sync1_q, sync2_q, lvl_q, lvl_d, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   // count cycles of disagreement; accept the new level once it has held long enough
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (sync2_q != lvl_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = sync2_q;
         else cnt_d = cnt_q + CW'(1);
      end
   end
   // synchroniser, debounce state and previous level for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         prev_q  <= lvl_q;
      end
   end
   assign press_o = lvl_q & ~prev_q;
endmodule

// File: rtl/sr_pulse_ctrl.sv
// sr_pulse_ctrl: turn debounced button presses into exclusive fixed-width active-low S/R pulses
module sr_pulse_ctrl
   import sr_pulse_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic set_btn,
   input  logic reset_btn,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);
   localparam int PW = $clog2(PULSE_CYCLES + 1);
   logic set_ev, rst_ev;
   state_e state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic s_q, s_d, r_q, r_d, busy_q, busy_d, conflict_q, conflict_d;
   sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
      .clk(clk), .rst(rst), .btn_i(set_btn), .press_o(set_ev)
   );
   sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
      .clk(clk), .rst(rst), .btn_i(reset_btn), .press_o(rst_ev)
   );
   // next state and output values; outputs derive from the next state so they are registered
   always_comb begin
      state_d    = state_q;
      pcnt_d     = '0;
      conflict_d = 1'b0;
      if (state_q == IDLE) begin
         state_d    = (set_ev && !rst_ev) ? SET_PULSE : (rst_ev && !set_ev) ? RST_PULSE : IDLE;
         conflict_d = set_ev && rst_ev;
      end else if (pcnt_q == PW'(PULSE_CYCLES - 1)) state_d = IDLE;
      else pcnt_d = pcnt_q + PW'(1);
      s_d    = state_d != SET_PULSE;
      r_d    = state_d != RST_PULSE;
      busy_d = state_d != IDLE;
   end
   // state, pulse counter and output registers; reset forces the latch inputs idle at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pcnt_q     <= '0;
         s_q        <= 1'b1;
         r_q        <= 1'b1;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         s_q        <= s_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end
   assign S        = s_q;
   assign R        = r_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;
endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// tb_sr_pulse_ctrl: directed stimulus with a cycle model of the button-to-pulse behaviour
module tb_sr_pulse_ctrl;
   localparam int DB = 4;
   localparam int PC = 3;
   logic clk = 1'b0, rst = 1'b0, set_btn = 1'b0, reset_btn = 1'b0;
   logic S, R, busy, conflict;
   int n_chk = 0, n_fail = 0, ecount = 0;
   sr_pulse_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PC)) dut (
      .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
      .S(S), .R(R), .busy(busy), .conflict(conflict)
   );
   always #5 clk = ~clk;
   // model: index 0 = set channel, 1 = reset channel
   bit [1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_prev = '0;
   int m_run[2] = '{0, 0};
   int m_left = 0, m_kind = 0;
   bit m_conf = 1'b0;
   always @(posedge clk or posedge rst) begin : model
      bit [1:0] ev, raw;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_prev = '0;
         m_run[0] = 0; m_run[1] = 0;
         m_left = 0; m_kind = 0; m_conf = 1'b0;
      end else begin
         raw = {reset_btn, set_btn};
         ev = m_lvl & ~m_prev;
         m_prev = m_lvl;
         for (int c = 0; c < 2; c++) begin
            if (m_s2[c] != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == DB) begin
                  m_lvl[c] = m_s2[c];
                  m_run[c] = 0;
               end
            end else m_run[c] = 0;
         end
         m_s2 = m_s1;
         m_s1 = raw;
         m_conf = 1'b0;
         if (m_left > 0) m_left--;
         else if (ev == 2'b11) m_conf = 1'b1;
         else if (ev != 2'b00) begin
            m_left = PC;
            m_kind = ev[0] ? 1 : 2;
         end
      end
   end
   task automatic chk(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t edge %0d: got %b, expected %b", nm, $time, ecount, act, exp);
      end
   endtask
   task automatic cmp();
      chk("S", S, !(m_left > 0 && m_kind == 1));
      chk("R", R, !(m_left > 0 && m_kind == 2));
      chk("busy", busy, m_left > 0);
      chk("conflict", conflict, m_conf);
      chk("never_both_low", S | R, 1'b1);
   endtask
   task automatic tick();
      @(posedge clk);
      ecount++;
      @(negedge clk);
      cmp();
   endtask
   task automatic run_to(input int e);
      while (ecount < e) tick();
   endtask
   task automatic settle();
      set_btn = 1'b0;
      reset_btn = 1'b0;
      repeat (12) tick();
   endtask
   int b;
   initial begin
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_btn = i[0];
         reset_btn = i[1];
         tick();
         chk("rst_S", S, 1'b1);
         chk("rst_R", R, 1'b1);
      end
      set_btn = 1'b0;
      reset_btn = 1'b0;
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("post_rst_busy", busy, 1'b0);
      // clean set press
      set_btn = 1'b1;
      b = ecount + 1;
      run_to(b + 5);
      chk("set_before", S, 1'b1);
      run_to(b + 6);
      chk("set_low", S, 1'b0);
      chk("set_busy", busy, 1'b1);
      run_to(b + 8);
      chk("set_still_low", S, 1'b0);
      run_to(b + 9);
      chk("set_high", S, 1'b1);
      chk("set_busy_off", busy, 1'b0);
      settle();
      // bouncing reset press
      reset_btn = 1'b1;
      tick();
      tick();
      reset_btn = 1'b0;
      tick();
      reset_btn = 1'b1;
      b = ecount + 1;
      run_to(b + 5);
      chk("bounce_R_before", R, 1'b1);
      run_to(b + 6);
      chk("bounce_R_low", R, 1'b0);
      run_to(b + 9);
      chk("bounce_R_high", R, 1'b1);
      run_to(b + 20);
      chk("bounce_single", R, 1'b1);
      settle();
      // simultaneous presses
      set_btn = 1'b1;
      reset_btn = 1'b1;
      b = ecount + 1;
      run_to(b + 6);
      chk("conf_on", conflict, 1'b1);
      chk("conf_busy", busy, 1'b0);
      run_to(b + 7);
      chk("conf_off", conflict, 1'b0);
      chk("conf_S", S, 1'b1);
      settle();
      // reset press dropped while a set pulse runs
      set_btn = 1'b1;
      b = ecount + 1;
      tick();
      reset_btn = 1'b1;
      run_to(b + 6);
      chk("drop_S_low", S, 1'b0);
      run_to(b + 7);
      chk("drop_R", R, 1'b1);
      run_to(b + 20);
      chk("drop_R_late", R, 1'b1);
      settle();
      // asynchronous reset mid-pulse
      set_btn = 1'b1;
      b = ecount + 1;
      run_to(b + 7);
      chk("async_pre", S, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("async_S", S, 1'b1);
      chk("async_busy", busy, 1'b0);
      set_btn = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("async_after", S, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
